modn_updown_counter: RTL

//  Parametrised synchronous modulo-N up/down counter with load, clear, cascade enables and RCO.

---
 rtl/counter_pkg.sv | 15 +
 rtl/modn_updown_counter_tc_detect.sv | 26 ++
 rtl/modn_updown_counter.sv | 96 +++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared counter constants and load-value clamp helper
// Purpose : overflow-mode encodings and a clamp function for modulo-N counters.
// Contents: CNT_MODE_WRAP, CNT_MODE_SAT, clamp_mod()
package counter_pkg;

   localparam int CNT_MODE_WRAP = 0;
   localparam int CNT_MODE_SAT  = 1;

   // Clamp a value into 0..modulus-1; out-of-range values pin to the top.
   function automatic logic [63:0] clamp_mod(input logic [63:0] i_val,
                                             input logic [63:0] i_modulus);
      return (i_val < i_modulus) ? i_val : (i_modulus - 64'd1);
   endfunction

endpackage

// File: rtl/modn_updown_counter_tc_detect.sv
// rtl/modn_updown_counter_tc_detect.sv - terminal-count detector for modulo-N counters
// Purpose : flags count at its top (MODULUS-1) or bottom (0) and selects the
//           terminal count for the current direction.
// Ports   : i_count  in  WIDTH  current count
//           i_up     in  1      direction, 1 = up
//           o_at_max out 1      count == MODULUS-1
//           o_at_min out 1      count == 0
//           o_tc     out 1      terminal count for the current direction
module tc_detect #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 16
) (
   input  logic [WIDTH-1:0] i_count,
   input  logic             i_up,
   output logic             o_at_max,
   output logic             o_at_min,
   output logic             o_tc
);

   localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MODULUS - 1);

   assign o_at_max = (i_count == C_MAX);
   assign o_at_min = (i_count == '0);
   assign o_tc     = i_up ? o_at_max : o_at_min;

endmodule

// File: rtl/modn_updown_counter.sv
// rtl/modn_updown_counter.sv - modulo-N up/down counter with load, clear, cascade enables, rco
// Purpose : parametrised synchronous modulo-N counter, wrap or saturate at
//           terminal count, chainable through rco -> ent.
// Ports   : clk   in  1      clock, rising edge
//           rst   in  1      asynchronous active-high reset
//           clr   in  1      synchronous clear (count and ovf)
//           load  in  1      synchronous load of din (clamped to MODULUS-1)
//           din   in  WIDTH  load value
//           enp   in  1      parallel count enable
//           ent   in  1      trickle count enable, gates rco
//           up    in  1      direction, 1 = up
//           count out WIDTH  registered count
//           rco   out 1      ripple carry out, combinational
//           ovf   out 1      sticky wrap/saturate flag
module modn_updown_counter
   import counter_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 16,
   parameter int SAT     = CNT_MODE_WRAP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic             enp,
   input  logic             ent,
   input  logic             up,
   output logic [WIDTH-1:0] count,
   output logic             rco,
   output logic             ovf
);

   if (WIDTH < 1 || MODULUS < 2 ||
       longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_params
      $error("modn_updown_counter: illegal WIDTH/MODULUS combination");
   end

   localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] r_count;
   logic             r_ovf;
   logic             w_at_max;
   logic             w_at_min;
   logic             w_tc;
   logic [WIDTH-1:0] w_din_clamped;

   tc_detect #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS)
   ) u_tc_detect (
      .i_count  (r_count),
      .i_up     (up),
      .o_at_max (w_at_max),
      .o_at_min (w_at_min),
      .o_tc     (w_tc)
   );

   assign w_din_clamped = WIDTH'(clamp_mod(64'(din), 64'(MODULUS)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else if (clr) begin
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else if (load) begin
         r_count <= w_din_clamped;
      end else if (enp && ent) begin
         if (up) begin
            if (!w_at_max) begin
               r_count <= r_count + WIDTH'(1);
            end else begin
               // At the top: wrap to 0 unless saturating, flag either way.
               r_ovf <= 1'b1;
               if (SAT != CNT_MODE_SAT) r_count <= '0;
            end
         end else begin
            if (!w_at_min) begin
               r_count <= r_count - WIDTH'(1);
            end else begin
               r_ovf <= 1'b1;
               if (SAT != CNT_MODE_SAT) r_count <= C_MAX;
            end
         end
      end
   end

   // enp deliberately does not gate rco so a cascade can pause on enp alone.
   assign rco   = ent & w_tc;
   assign count = r_count;
   assign ovf   = r_ovf;

endmodule
